pattern_fsm: RTL and testbench
==============================

PATTERN_FSM -- requirements
Module: pattern_fsm

Interface
REQ-001 Parameter PAT_W, default 4: pattern length in bits, legal range 2..32.
REQ-002 Parameter PATTERN, default 4'b1011: target pattern; the MSB is the oldest bit received.
REQ-003 Parameter OVERLAP, default 1: 1 keeps history after a hit; 0 restarts collection after a hit.
REQ-004 Parameter MOORE, default 0: 0 gives a combinational (Mealy) hit; 1 gives a registered (Moore) hit one cycle later.
REQ-005 Parameter CNT_W, default 8: width of the hit counter.
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 en  input  1  detector enable; when 0, bits are ignored and state is held.
REQ-009 clr  input  1  synchronous clear of history, fill level, counter and flags.
REQ-010 din_vld  input  1  din carries a valid serial bit this cycle.
REQ-011 din  input  1  serial data bit.
REQ-012 hit  output  1  pattern-complete pulse.
REQ-013 hit_cnt  output  CNT_W  number of hits since the last reset or clr, saturating.
REQ-014 cnt_sat  output  1  sticky flag, set when hit_cnt reaches its maximum.
REQ-015 state_o  output  2  current FSM state, for debug.

Function
REQ-016 A bit is accepted only when en=1, din_vld=1 and clr=0.
REQ-017 The FSM shall have three states: IDLE=0, FILL=1, HUNT=2.
REQ-018 IDLE: moves to FILL on the first accepted bit.
REQ-019 FILL: fill count below PAT_W-1; moves to HUNT when an accepted bit makes the count equal PAT_W-1.
REQ-020 HUNT: history holds PAT_W-1 valid bits.
REQ-021 The block shall keep a history register of PAT_W-1 bits; each accepted bit shifts in at the LSB.
REQ-022 raw_hit = (state==HUNT) AND the bit is accepted AND {history,din}==PATTERN.
REQ-023 With MOORE=0, hit = raw_hit in the same cycle, with zero latency.
REQ-024 With MOORE=1, hit = raw_hit registered, one cycle later, and high for exactly one cycle per hit.
REQ-025 With OVERLAP=1, a raw_hit shifts in normally and the state stays HUNT.
REQ-026 With OVERLAP=0, a raw_hit clears the fill count and the state goes to FILL; the history contents are don't-care.
REQ-027 Each raw_hit increments hit_cnt by 1, saturating at 2^CNT_W-1.
REQ-028 cnt_sat is set on the cycle hit_cnt becomes the maximum and stays set until clr or reset.
REQ-029 clr has priority over an accepted bit: it forces IDLE, clears history, fill count, hit_cnt and cnt_sat, and clears the Moore hit register.
REQ-030 When clr=1, the Mealy hit is 0.
REQ-031 While en=0, everything is held, including gaps in din_vld and a partial pattern; a Moore hit already registered still emits.
REQ-032 Cycles with din_vld=0 do not break a partial match.

Reset
REQ-033 When rst_n=0, asynchronously: state=IDLE, history=0, fill count=0, hit=0, hit_cnt=0, cnt_sat=0.
REQ-034 Reset asserted mid-pattern discards the partial match; no hit is produced from bits accepted before reset.
REQ-035 Release of reset is synchronous to clk and is clean on the first edge after rst_n rises.

Structure
REQ-036 A shared package shall hold the state encoding constants (IDLE/FILL/HUNT) and the state width of 2.
REQ-037 The saturating counter shall be a sub-module, sat_counter (parameter W; ports inc, clr, cnt, sat), instantiated once.
REQ-038 The RTL shall be elaborated for PAT_W=2 and PAT_W=32 without width warnings.

Verification
REQ-039 Defaults, din 1,0,1,1,0,1,1 on consecutive cycles -> hit on the 4th and 7th bits, hit_cnt=2.
REQ-040 OVERLAP=0, same stream -> hit on the 4th bit only, hit_cnt=1; the next hit requires 4 fresh bits.
REQ-041 MOORE=1, stream 1,0,1,1 -> hit 1 cycle after the 4th bit and high for exactly one cycle; the same stream with din_vld gaps of 3 cycles still hits.
REQ-042 CNT_W=2, 5 hits -> hit_cnt stays 3 after the 3rd hit, and cnt_sat=1 from that cycle.
REQ-043 Stream 1,0,1, then clr together with din=1 valid -> no hit, state IDLE; subsequent 1,0,1,1 -> one hit.
REQ-044 Stream 1,0,1, then rst_n pulsed low between edges -> outputs 0 immediately; subsequent 1 -> no hit.

Source files
------------

// File: rtl/pattern_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pattern_fsm_pkg
// Brief    : State encoding shared by the serial pattern detector.
// Revision : 1.0
// ============================================================================
package pattern_fsm_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HUNT = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/pattern_fsm_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : Saturating event counter with a sticky saturation flag.
// Revision : 1.0
// ============================================================================
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         sat
);

  localparam logic [W-1:0] c_cnt_max = '1;

  logic [W-1:0] cnt_q, cnt_d;
  logic         sat_q, sat_d;

  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (clr) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else begin
      if (inc && (cnt_q != c_cnt_max)) begin
        cnt_d = cnt_q + 1'b1;
      end
      // flag rises on the same edge that loads the maximum count
      if (cnt_d == c_cnt_max) begin
        sat_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign cnt = cnt_q;
  assign sat = sat_q;

endmodule
`default_nettype wire

// File: rtl/pattern_fsm.sv
`default_nettype none
// ============================================================================
// Module   : pattern_fsm
// Brief    : Serial bit-pattern detector with fill/hunt FSM and hit counter.
// Revision : 1.0
// ============================================================================
module pattern_fsm
  import pattern_fsm_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(4'b1011),
  parameter int               OVERLAP = 1,
  parameter int               MOORE   = 0,
  parameter int               CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clr,
  input  logic               din_vld,
  input  logic               din,
  output logic               hit,
  output logic [CNT_W-1:0]   hit_cnt,
  output logic               cnt_sat,
  output logic [STATE_W-1:0] state_o
);

  localparam int               FILL_W      = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] c_fill_full = FILL_W'(PAT_W - 1);

  state_e             state_q, state_d;
  logic [PAT_W-2:0]   hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [PAT_W-1:0]   shift_w;
  logic               accept;
  logic               raw_hit;

  assign accept  = en & din_vld & ~clr;
  assign shift_w = {hist_q, din};
  assign raw_hit = (state_q == HUNT) & accept & (shift_w == PATTERN);

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    if (clr) begin
      state_d = IDLE;
      hist_d  = '0;
      fill_d  = '0;
    end else if (accept) begin
      hist_d = shift_w[PAT_W-2:0];
      if (raw_hit && (OVERLAP == 0)) begin
        fill_d  = '0;
        state_d = FILL;
      end else if (state_q != HUNT) begin
        // a one-bit history (PAT_W=2) is complete after the very first bit
        fill_d  = fill_q + 1'b1;
        state_d = (fill_d == c_fill_full) ? HUNT : FILL;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hist_q  <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
    end
  end

  generate
    if (MOORE != 0) begin : g_moore
      logic hit_q, hit_d;

      always_comb begin
        hit_d = raw_hit & ~clr;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          hit_q <= 1'b0;
        end else begin
          hit_q <= hit_d;
        end
      end

      assign hit = hit_q;
    end else begin : g_mealy
      assign hit = raw_hit;
    end
  endgenerate

  sat_counter #(
    .W (CNT_W)
  ) u_hit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (raw_hit),
    .clr   (clr),
    .cnt   (hit_cnt),
    .sat   (cnt_sat)
  );

  assign state_o = state_q;

endmodule
`default_nettype wire

// File: tb/tb_pattern_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_pattern_fsm
// Brief    : Self-checking bench for pattern_fsm across six configurations.
// Revision : 1.0
// ============================================================================
module tb_pattern_fsm;

  logic clk = 1'b0;
  logic rst_n, en, clr, din_vld, din;

  always #5 clk = ~clk;

  logic       h0, h1, h2, h3, h4, h5;
  logic       s0, s1, s2, s3, s4, s5;
  logic [1:0] st0, st1, st2, st3, st4, st5;
  logic [7:0] c0, c1, c2, c4, c5;
  logic [1:0] c3;

  pattern_fsm u_d0 (.clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .din_vld(din_vld), .din(din),
                    .hit(h0), .hit_cnt(c0), .cnt_sat(s0), .state_o(st0));
  pattern_fsm #(.OVERLAP(0)) u_d1 (.clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .din_vld(din_vld),
                    .din(din), .hit(h1), .hit_cnt(c1), .cnt_sat(s1), .state_o(st1));
  pattern_fsm #(.MOORE(1)) u_d2 (.clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .din_vld(din_vld),
                    .din(din), .hit(h2), .hit_cnt(c2), .cnt_sat(s2), .state_o(st2));
  pattern_fsm #(.CNT_W(2)) u_d3 (.clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .din_vld(din_vld),
                    .din(din), .hit(h3), .hit_cnt(c3), .cnt_sat(s3), .state_o(st3));
  pattern_fsm #(.PAT_W(2), .PATTERN(2'b01), .MOORE(1), .OVERLAP(0)) u_d4 (.clk(clk), .rst_n(rst_n),
                    .en(en), .clr(clr), .din_vld(din_vld), .din(din),
                    .hit(h4), .hit_cnt(c4), .cnt_sat(s4), .state_o(st4));
  pattern_fsm #(.PAT_W(32), .PATTERN(32'hA5C3_0F96)) u_d5 (.clk(clk), .rst_n(rst_n), .en(en),
                    .clr(clr), .din_vld(din_vld), .din(din),
                    .hit(h5), .hit_cnt(c5), .cnt_sat(s5), .state_o(st5));

  logic [35:0] obs [6];
  assign obs[0] = {h0, s0, st0, 24'd0, c0};
  assign obs[1] = {h1, s1, st1, 24'd0, c1};
  assign obs[2] = {h2, s2, st2, 24'd0, c2};
  assign obs[3] = {h3, s3, st3, 30'd0, c3};
  assign obs[4] = {h4, s4, st4, 24'd0, c4};
  assign obs[5] = {h5, s5, st5, 24'd0, c5};

  int n_chk = 0;
  int n_pass = 0;

  // reference model: configuration and abstract state per instance
  int          m_pw    [6];
  logic [31:0] m_pat   [6];
  bit          m_ov    [6];
  bit          m_moore [6];
  int          m_cw    [6];
  bit          m_seen  [6];
  int          m_n     [6];
  logic [63:0] m_hist  [6];
  int          m_cnt   [6];
  bit          m_sat   [6];
  bit          m_pend  [6];
  logic [35:0] exp_obs [6];

  task automatic model_reset();
    for (int i = 0; i < 6; i++) begin
      m_seen[i] = 1'b0; m_n[i] = 0; m_hist[i] = '0;
      m_cnt[i] = 0; m_sat[i] = 1'b0; m_pend[i] = 1'b0;
    end
  endtask

  function automatic bit model_raw(int i, bit e, bit c, bit v, bit d);
    logic [63:0] mask, win;
    if (!(e && v && !c) || (m_n[i] < m_pw[i] - 1)) return 1'b0;
    mask = (64'd1 << m_pw[i]) - 64'd1;
    win  = ((m_hist[i] << 1) | 64'(d)) & mask;
    return win == (64'(m_pat[i]) & mask);
  endfunction

  function automatic logic [1:0] model_state(int i);
    if (!m_seen[i]) return 2'd0;
    return (m_n[i] >= m_pw[i] - 1) ? 2'd2 : 2'd1;
  endfunction

  // apply one cycle of inputs at the falling edge; exp_obs holds what the
  // outputs must show before the next rising edge
  task automatic drive(input bit e, input bit c, input bit v, input bit d);
    bit r;
    @(negedge clk);
    en = e; clr = c; din_vld = v; din = d;
    #1;
    for (int i = 0; i < 6; i++) begin
      r = model_raw(i, e, c, v, d);
      exp_obs[i] = {(m_moore[i] ? m_pend[i] : r), m_sat[i], model_state(i), 32'(m_cnt[i])};
      if (c) begin
        m_seen[i] = 1'b0; m_n[i] = 0; m_hist[i] = '0;
        m_cnt[i] = 0; m_sat[i] = 1'b0; m_pend[i] = 1'b0;
      end else if (e && v) begin
        m_hist[i] = (m_hist[i] << 1) | 64'(d);
        m_seen[i] = 1'b1;
        if (r && !m_ov[i]) m_n[i] = 0;
        else if (m_n[i] < 64) m_n[i] = m_n[i] + 1;
        if (r && (m_cnt[i] < (1 << m_cw[i]) - 1)) m_cnt[i] = m_cnt[i] + 1;
        if (m_cnt[i] == (1 << m_cw[i]) - 1) m_sat[i] = 1'b1;
        m_pend[i] = r;
      end else begin
        m_pend[i] = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; en = 1'b0; clr = 1'b0; din_vld = 1'b0; din = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    for (int i = 0; i < 6; i++) begin
      n_chk++;
      if (obs[i] !== 36'd0) $display("FAIL reset dut%0d: got %h want 0", i, obs[i]);
      else n_pass++;
    end
    model_reset();
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_basic_stream();
    logic [6:0] seq = 7'b1011011;
    logic [6:0] hits0 = '0, hits1 = '0;
    for (int k = 6; k >= 0; k--) begin
      drive(1, 0, 1, seq[k]);
      hits0 = {hits0[5:0], h0};
      hits1 = {hits1[5:0], h1};
      for (int i = 0; i < 6; i++) begin
        n_chk++;
        if (obs[i] !== exp_obs[i]) $display("FAIL basic dut%0d bit%0d: got %h want %h", i, 6 - k, obs[i], exp_obs[i]);
        else n_pass++;
      end
    end
    drive(1, 0, 0, 0);
    n_chk++;
    if (hits0 !== 7'b0001001) $display("FAIL basic_hits_ovl: got %b want 0001001", hits0);
    else n_pass++;
    n_chk++;
    if (hits1 !== 7'b0001000) $display("FAIL basic_hits_noovl: got %b want 0001000", hits1);
    else n_pass++;
    n_chk++;
    if (c0 !== 8'd2) $display("FAIL basic_cnt_ovl: got %0d want 2", c0);
    else n_pass++;
    n_chk++;
    if (c1 !== 8'd1) $display("FAIL basic_cnt_noovl: got %0d want 1", c1);
    else n_pass++;
  endtask

  task automatic test_moore_gaps();
    logic [3:0] seq = 4'b1011;
    int nh = 0, hk = -1, k = 0;
    drive(1, 1, 0, 0);
    for (int b = 3; b >= 0; b--) begin
      for (int g = 0; g < 4; g++) begin
        if (g == 0) drive(1, 0, 1, seq[b]);
        else drive(1, 0, 0, 0);
        if (h2) begin nh++; hk = k; end
        for (int i = 0; i < 6; i++) begin
          n_chk++;
          if (obs[i] !== exp_obs[i]) $display("FAIL moore_gap dut%0d cyc%0d: got %h want %h", i, k, obs[i], exp_obs[i]);
          else n_pass++;
        end
        k++;
      end
    end
    n_chk++;
    if (nh !== 1 || hk !== 13) $display("FAIL moore_pulse: got %0d pulses at cyc %0d want 1 at 13", nh, hk);
    else n_pass++;
  endtask

  task automatic test_saturation();
    logic [15:0] seq = 16'b1011011011011011;
    drive(1, 1, 0, 0);
    for (int k = 0; k < 16; k++) begin
      drive(1, 0, 1, seq[15 - k]);
      if (k == 9 || k == 10) begin
        n_chk++;
        if (s3 !== (k == 10)) $display("FAIL sat_edge cyc%0d: got %b want %b", k, s3, k == 10);
        else n_pass++;
      end
      for (int i = 0; i < 6; i++) begin
        n_chk++;
        if (obs[i] !== exp_obs[i]) $display("FAIL sat dut%0d cyc%0d: got %h want %h", i, k, obs[i], exp_obs[i]);
        else n_pass++;
      end
    end
    drive(1, 0, 0, 0);
    n_chk++;
    if (c3 !== 2'd3 || s3 !== 1'b1) $display("FAIL sat_final: got cnt %0d sat %b want 3 1", c3, s3);
    else n_pass++;
  endtask

  task automatic test_clr_priority();
    logic [2:0] pre = 3'b101;
    logic [3:0] seq = 4'b1011;
    int nh = 0;
    drive(1, 1, 0, 0);
    for (int k = 2; k >= 0; k--) drive(1, 0, 1, pre[k]);
    drive(1, 1, 1, 1);
    n_chk++;
    if (h0 !== 1'b0) $display("FAIL clr_hit: got %b want 0", h0);
    else n_pass++;
    drive(1, 0, 0, 0);
    n_chk++;
    if (st0 !== 2'd0 || c0 !== 8'd0) $display("FAIL clr_state: got st %0d cnt %0d want 0 0", st0, c0);
    else n_pass++;
    for (int k = 3; k >= 0; k--) begin
      drive(1, 0, 1, seq[k]);
      if (h0) nh++;
      for (int i = 0; i < 6; i++) begin
        n_chk++;
        if (obs[i] !== exp_obs[i]) $display("FAIL clr_after dut%0d: got %h want %h", i, obs[i], exp_obs[i]);
        else n_pass++;
      end
    end
    n_chk++;
    if (nh !== 1) $display("FAIL clr_rehit: got %0d hits want 1", nh);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    logic [2:0] pre = 3'b101;
    drive(1, 1, 0, 0);
    for (int k = 2; k >= 0; k--) drive(1, 0, 1, pre[k]);
    @(posedge clk);
    #2;
    en = 1'b0; din_vld = 1'b0; rst_n = 1'b0;
    #1;
    for (int i = 0; i < 6; i++) begin
      n_chk++;
      if (obs[i] !== 36'd0) $display("FAIL async_rst dut%0d: got %h want 0", i, obs[i]);
      else n_pass++;
    end
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    drive(1, 0, 1, 1);
    n_chk++;
    if (h0 !== 1'b0) $display("FAIL rst_nohit: got %b want 0", h0);
    else n_pass++;
    drive(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      n_chk++;
      if (obs[i] !== exp_obs[i]) $display("FAIL rst_after dut%0d: got %h want %h", i, obs[i], exp_obs[i]);
      else n_pass++;
    end
  endtask

  task automatic test_pat32();
    logic last = 1'b0;
    drive(1, 1, 0, 0);
    for (int b = 31; b >= 0; b--) begin
      drive(1, 0, 1, m_pat[5][b]);
      if (b == 0) last = h5;
      for (int i = 0; i < 6; i++) begin
        n_chk++;
        if (obs[i] !== exp_obs[i]) $display("FAIL pat32 dut%0d bit%0d: got %h want %h", i, 31 - b, obs[i], exp_obs[i]);
        else n_pass++;
      end
    end
    n_chk++;
    if (last !== 1'b1) $display("FAIL pat32_hit: got %b want 1", last);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      drive(($urandom % 4) != 0, ($urandom % 40) == 0, ($urandom % 4) != 0, 1'($urandom % 2));
      for (int i = 0; i < 6; i++) begin
        n_chk++;
        if (obs[i] !== exp_obs[i]) $display("FAIL random dut%0d cyc%0d: got %h want %h", i, k, obs[i], exp_obs[i]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    m_pw    = '{4, 4, 4, 4, 2, 32};
    m_pat   = '{32'hB, 32'hB, 32'hB, 32'hB, 32'h1, 32'hA5C3_0F96};
    m_ov    = '{1, 0, 1, 1, 0, 1};
    m_moore = '{0, 0, 1, 0, 1, 0};
    m_cw    = '{8, 8, 8, 2, 8, 8};
    model_reset();
    test_reset();
    test_basic_stream();
    test_moore_gaps();
    test_saturation();
    test_clr_priority();
    test_async_reset();
    test_pat32();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
